// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM (one write port, one read port, shared clock) with registered read data.
// Define RAM_OUTREG_EN to add a second output register (read latency 2 instead of 1).
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  output logic [DATA_W-1:0] q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_reg;
  logic              wr_ok;
  logic              rd_ok;

  // Addresses at or beyond DEPTH only exist when DEPTH < 2**ADDR_W.
  assign wr_ok = wren && ({1'b0, wraddress} < DEPTH_L);
  assign rd_ok = ({1'b0, rdaddress} < DEPTH_L);

  // Array kept free of reset so it maps onto a block RAM; reset_n only gates the write.
  always_ff @(posedge clock) begin
    if (reset_n && wr_ok) begin
      mem[wraddress[IDX_W-1:0]] <= data;
    end
  end

  // Read-during-write to the same address returns the old word (no bypass path).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_reg <= '0;
    end else if (rden) begin
      rd_reg <= rd_ok ? mem[rdaddress[IDX_W-1:0]] : '0;
    end
  end

`ifdef RAM_OUTREG_EN
  logic              rden_reg;
  logic [DATA_W-1:0] q_reg;

  // Output stage only follows the array register one cycle after a real read, so q holds when reads stop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rden_reg <= 1'b0;
      q_reg    <= '0;
    end else begin
      rden_reg <= rden;
      if (rden_reg) begin
        q_reg <= rd_reg;
      end
    end
  end

  assign q = q_reg;
`else
  assign q = rd_reg;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed scenarios plus random traffic against a reference model.
// Honours RAM_OUTREG_EN for the expected read latency.
module tb_dual_port_ram;

  localparam int DW     = 8;
  localparam int AW     = 14;
  localparam int SDEPTH = 1000;
`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wren;
  logic          rden;
  logic [DW-1:0] data;
  logic [AW-1:0] wraddress;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic [DW-1:0] q_small;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words (only addresses ever written exist) and the
  // value of the most recent read as seen after this edge [0] and the edge before [1].
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] hist_v [2];
  bit            hist_k [2];

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q)
  );

  dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(SDEPTH)) u_small (
    .clock     (clk),
    .reset_n   (reset_n),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q_small)
  );

  task automatic check8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the rising edge, compare q on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset_n) begin
      hist_v[0] = '0; hist_v[1] = '0;
      hist_k[0] = 1'b1; hist_k[1] = 1'b1;
    end else begin
      hist_v[1] = hist_v[0];
      hist_k[1] = hist_k[0];
      if (rden) begin
        hist_k[0] = mem_m.exists(int'(rdaddress));
        hist_v[0] = hist_k[0] ? mem_m[int'(rdaddress)] : '0;
      end
      if (wren) mem_m[int'(wraddress)] = data;
    end
    @(negedge clk);
    if (hist_k[LAT-1]) check8(tag, q, hist_v[LAT-1]);
  endtask

  task automatic write1(input int addr, input logic [DW-1:0] d);
    wren = 1'b1; wraddress = AW'(addr); data = d;
    tick("write");
    wren = 1'b0;
  endtask

  // Issue a read, then one idle cycle so the result is on q for either latency.
  task automatic read1(input int addr);
    rden = 1'b1; rdaddress = AW'(addr);
    tick("read");
    rden = 1'b0;
    tick("read_idle");
  endtask

  initial begin
    reset_n = 1'b0; wren = 1'b0; rden = 1'b0; data = '0;
    wraddress = '0; rdaddress = '0;
    hist_v[0] = '0; hist_v[1] = '0; hist_k[0] = 1'b1; hist_k[1] = 1'b1;

    // Reset state
    repeat (2) tick("reset_q");
    check8("reset_q_small", q_small, 8'h00);
    reset_n = 1'b1;

    // Asynchronous reset while q holds A5, memory survives, writes in reset ignored
    write1(10, 8'hA5);
    read1(10);
    check8("pre_reset_q", q, 8'hA5);
    #2 reset_n = 1'b0;
    #1 check8("async_reset_q", q, 8'h00);
    wren = 1'b1; wraddress = AW'(10); data = 8'h77;
    rden = 1'b1; rdaddress = AW'(10);
    tick("in_reset");
    wren = 1'b0; rden = 1'b0;
    reset_n = 1'b1;
    write1(5, 8'h3C);
    read1(5);
    check8("post_reset_read5", q, 8'h3C);
    read1(10);
    check8("mem_kept_over_reset", q, 8'hA5);

    // Basic back-to-back reads including the top address
    write1(0, 8'h11);
    write1(1, 8'h22);
    write1(16383, 8'h33);
    rden = 1'b1; rdaddress = AW'(0);     tick("basic0");
    rdaddress = AW'(1);                  tick("basic1");
    rdaddress = AW'(16383);              tick("basic2");
    rden = 1'b0;                         tick("basic_idle");
    check8("basic_top", q, 8'h33);

    // Hold: q keeps the last read while the word underneath changes
    rden = 1'b1; rdaddress = AW'(1); tick("hold_rd");
    rden = 1'b0; wren = 1'b1; wraddress = AW'(1); data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick("hold");
      check8("hold_q", q, 8'h22);
    end
    wren = 1'b0;

    // Read-during-write to the same address returns the old word
    write1(7, 8'h01);
    wren = 1'b1; wraddress = AW'(7); data = 8'h02;
    rden = 1'b1; rdaddress = AW'(7);
    tick("rdw");
    wren = 1'b0; rden = 1'b0;
    tick("rdw_idle");
    check8("rdw_old", q, 8'h01);
    read1(7);
    check8("rdw_new", q, 8'h02);

    // Concurrent streaming: write i while reading i-2
    for (int i = 0; i < 256; i++) begin
      wren = 1'b1; wraddress = AW'(i); data = DW'(i);
      rden = (i >= 2); rdaddress = AW'(i - 2);
      tick("stream");
    end
    wren = 1'b0; rden = 1'b0;
    tick("stream_idle");
    check8("stream_last", q, 8'hFD);

    // Random traffic on a small address window, with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      reset_n   = ($urandom_range(0, 49) != 0);
      wren      = 1'($urandom_range(0, 1));
      wraddress = AW'($urandom_range(0, 63));
      data      = DW'($urandom);
      rden      = 1'($urandom_range(0, 1));
      rdaddress = AW'($urandom_range(0, 63));
      tick("random");
    end
    reset_n = 1'b1; wren = 1'b0; rden = 1'b0;
    tick("random_idle");

    // Out-of-range accesses on the DEPTH=1000 instance
    write1(0, 8'h5A);
    write1(500, 8'h6E);
    write1(999, 8'hC3);
    wren = 1'b1; wraddress = AW'(1000); data = 8'hAA;
    rden = 1'b1; rdaddress = AW'(0);
    tick("oor_write");
    wren = 1'b0; rden = 1'b0;
    tick("oor_idle");
    check8("small_read0", q_small, 8'h5A);
    read1(1000);
    check8("oor_read", q_small, 8'h00);
    read1(999);
    check8("small_read999", q_small, 8'hC3);
    read1(500);
    check8("small_read500", q_small, 8'h6E);
    read1(0);
    check8("small_read0_after", q_small, 8'h5A);
    read1(1000);
    check8("big_read1000", q, 8'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
